rmii_frame_tx: RTL and testbench

- RMII transmit framer; the transmit-direction counterpart of the Ethernet receive path feeding the CPU's memory-mapped EthNew/EthData registers.
- Takes one 32-bit CPU word and emits one complete minimum-size Ethernet II frame on TXD1/TXD0/TXEN:
  - preamble, SFD, fixed header, payload, zero pad, CRC-32 FCS;
  - then enforces the inter-frame gap.
- Driven by the memory-mapped send-data and send-enable registers; reports completion through a sticky finish flag that the CPU polls.

---
 rtl/rmii_frame_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rmii_frame_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_frame_tx.sv
//------------------------------------------------------------------------------
// rmii_frame_tx
//
// RMII transmit framer. One 32-bit CPU word becomes one minimum-size Ethernet II
// frame on TXD1/TXD0/TXEN. The frame is preamble, SFD, fixed header, the four
// payload octets, zero pad and the CRC-32 FCS. The framer then holds the line
// idle for the inter-frame gap and raises a sticky finish flag for the CPU.
//
// Ports
//   clk          system clock (100 MHz nominal)
//   reset        synchronous, active-high reset
//   send_data    payload word, captured only on the accept cycle
//   send_ena     start request, rising-edge sensitive
//   send_finish  sticky done flag: set after the last IFG slot, cleared by the
//                next accept or by reset
//   busy         high from the accept cycle until the end of the IFG
//   TXD1, TXD0   RMII dibit, bit 1 and bit 0
//   TXEN         RMII transmit enable
//
// Parameters
//   CLK_DIV      clk cycles per RMII dibit slot, legal range 2..15
//   DST_MAC      destination MAC, bits [47:40] sent first
//   SRC_MAC      source MAC, bits [47:40] sent first
//   ETHERTYPE    EtherType, high octet first
//------------------------------------------------------------------------------
module rmii_frame_tx #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC   = 48'h000A_3500_0001,
    parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] send_data,
    input  logic        send_ena,
    output logic        send_finish,
    output logic        busy,
    output logic        TXD1,
    output logic        TXD0,
    output logic        TXEN
);

    // Reflected IEEE 802.3 polynomial.
    localparam logic [31:0]  CRC_POLY = 32'hEDB8_8320;

    // Header as one vector; octet 0 is the top byte.
    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

    localparam logic [3:0]   DIV_LAST = 4'(CLK_DIV - 1);

    // Last dibit index of each section. The gap counts one slot further: slots
    // 0..47 are the gap proper, and the tick that would open slot 48 is the one
    // that closes the gap and raises send_finish.
    localparam logic [7:0]   PRE_LAST = 8'd27;   // 7 octets of 0x55
    localparam logic [7:0]   SFD_LAST = 8'd3;    // 0xD5
    localparam logic [7:0]   HDR_LAST = 8'd55;   // 14 header octets
    localparam logic [7:0]   PAY_LAST = 8'd15;   // 4 payload octets
    localparam logic [7:0]   PAD_LAST = 8'd167;  // 42 zero octets
    localparam logic [7:0]   FCS_LAST = 8'd15;   // 4 FCS octets
    localparam logic [7:0]   IFG_END  = 8'd48;   // 48 idle slots

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;        // dibit index within the current section
    logic [3:0]  div_q, div_d;        // free-running dibit slot divider
    logic        ena_q;               // previous send_ena sample
    logic        armed_q;             // send_ena has been seen low since reset
    logic        busy_q, busy_d;
    logic        finish_q, finish_d;
    logic [1:0]  txd_q, txd_d;
    logic        txen_q, txen_d;
    logic [31:0] data_q, data_d;
    logic [31:0] crc_q, crc_d;

    logic        tick;
    logic        accept;
    logic        cnt_last;
    logic [7:0]  octet;
    logic [1:0]  dibit;

    // Two CRC steps, bit 0 of the dibit first, matching LSB-first wire order.
    function automatic logic [31:0] crc_step2(input logic [31:0] c,
                                              input logic [1:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    function automatic logic [7:0] hdr_octet(input logic [3:0] idx);
        logic [7:0] o;
        o = 8'h00;
        for (int i = 0; i < 14; i++) begin
            if (idx == 4'(i)) begin
                o = HDR[8*(13-i) +: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t next_section(input state_t s);
        state_t n;
        case (s)
            ST_PRE:  n = ST_SFD;
            ST_SFD:  n = ST_HDR;
            ST_HDR:  n = ST_PAY;
            ST_PAY:  n = ST_PAD;
            ST_PAD:  n = ST_FCS;
            ST_FCS:  n = ST_IFG;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

    assign tick = (div_q == DIV_LAST);
    assign div_d = tick ? 4'd0 : div_q + 4'd1;

    // A level already high when reset releases is not an edge: armed_q only
    // sets once send_ena has been sampled low.
    assign accept = (state_q == ST_IDLE) && send_ena && !ena_q && armed_q;

    // Dibit for the slot about to start: pick the octet for this section, then
    // the 2-bit group selected by the low counter bits (LSB pair first).
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        octet = 8'h00;
        dibit = 2'b00;
        case (state_q)
            ST_PRE:  octet = 8'h55;
            ST_SFD:  octet = 8'hD5;
            ST_HDR:  octet = hdr_octet(cnt_q[5:2]);
            ST_PAY: begin
                case (cnt_q[3:2])
                    2'd0:    octet = data_q[31:24];
                    2'd1:    octet = data_q[23:16];
                    2'd2:    octet = data_q[15:8];
                    default: octet = data_q[7:0];
                endcase
            end
            default: octet = 8'h00;
        endcase
        case (cnt_q[1:0])
            2'd0:    dibit = octet[1:0];
            2'd1:    dibit = octet[3:2];
            2'd2:    dibit = octet[5:4];
            default: dibit = octet[7:6];
        endcase
        // FCS goes out as the inverted register, shifted two bits per slot.
        if (state_q == ST_FCS) begin
            dibit = ~crc_q[1:0];
        end
    end

    always_comb begin
        cnt_last = 1'b0;
        case (state_q)
            ST_PRE:  cnt_last = (cnt_q == PRE_LAST);
            ST_SFD:  cnt_last = (cnt_q == SFD_LAST);
            ST_HDR:  cnt_last = (cnt_q == HDR_LAST);
            ST_PAY:  cnt_last = (cnt_q == PAY_LAST);
            ST_PAD:  cnt_last = (cnt_q == PAD_LAST);
            ST_FCS:  cnt_last = (cnt_q == FCS_LAST);
            ST_IFG:  cnt_last = (cnt_q == IFG_END);
            default: cnt_last = 1'b0;
        endcase
    end

    // Next-state and output logic. Outputs are registered and only reloaded
    // on tick, so the line changes once per dibit slot.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        finish_d = finish_q;
        txd_d    = txd_q;
        txen_d   = txen_q;
        data_d   = data_q;
        crc_d    = crc_q;

        if (state_q == ST_IDLE) begin
            txd_d  = 2'b00;
            txen_d = 1'b0;
            if (accept) begin
                state_d  = ST_PRE;
                cnt_d    = 8'd0;
                busy_d   = 1'b1;
                finish_d = 1'b0;
                data_d   = send_data;
                crc_d    = 32'hFFFF_FFFF;
            end
        end else if (tick) begin
            txd_d  = (state_q == ST_IFG) ? 2'b00 : dibit;
            txen_d = (state_q != ST_IFG);
            cnt_d  = cnt_last ? 8'd0 : cnt_q + 8'd1;

            case (state_q)
                ST_HDR, ST_PAY, ST_PAD: crc_d = crc_step2(crc_q, dibit);
                ST_FCS:                 crc_d = crc_q >> 2;
                default:                crc_d = crc_q;
            endcase

            if (cnt_last) begin
                state_d = next_section(state_q);
                if (state_q == ST_IFG) begin
                    busy_d   = 1'b0;
                    finish_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            div_q    <= 4'd0;
            ena_q    <= 1'b0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            txd_q    <= 2'b00;
            txen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            ena_q    <= send_ena;
            armed_q  <= armed_q | ~send_ena;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            txd_q    <= txd_d;
            txen_q   <= txen_d;
        end
    end

    // NOTE: the payload and CRC registers are datapath only and are left out
    // of reset; both are loaded on accept before anything reads them.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        crc_q  <= crc_d;
    end

    assign send_finish = finish_q;
    assign busy        = busy_q;
    assign TXD1        = txd_q[1];
    assign TXD0        = txd_q[0];
    assign TXEN        = txen_q;

endmodule

// File: tb/tb_rmii_frame_tx.sv
//------------------------------------------------------------------------------
// tb_rmii_frame_tx
//
// Directed bench for rmii_frame_tx. Two instances share the clock and reset:
// u_dut2 with CLK_DIV=2 and u_dut4 with CLK_DIV=4. The expected octets of each
// frame are pushed to a queue when the request is driven. They are popped as
// the decoded line produces octets.
//------------------------------------------------------------------------------
module tb_rmii_frame_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data2, data4;
    logic        ena2, ena4;
    logic        fin2, busy2, txd1_2, txd0_2, txen2;
    logic        fin4, busy4, txd1_4, txd0_4, txen4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    logic [7:0] hdr_bytes [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                   8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01,
                                   8'h88, 8'hB5};

    always #5 clk = ~clk;

    rmii_frame_tx #(.CLK_DIV(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .send_data   (data2),
        .send_ena    (ena2),
        .send_finish (fin2),
        .busy        (busy2),
        .TXD1        (txd1_2),
        .TXD0        (txd0_2),
        .TXEN        (txen2)
    );

    rmii_frame_tx #(.CLK_DIV(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .send_data   (data4),
        .send_ena    (ena4),
        .send_finish (fin4),
        .busy        (busy4),
        .TXD1        (txd1_4),
        .TXD0        (txd0_4),
        .TXEN        (txen4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic s_txen(input bit u4);
        return u4 ? txen4 : txen2;
    endfunction

    function automatic logic [1:0] s_txd(input bit u4);
        return u4 ? {txd1_4, txd0_4} : {txd1_2, txd0_2};
    endfunction

    function automatic logic s_busy(input bit u4);
        return u4 ? busy4 : busy2;
    endfunction

    function automatic logic s_fin(input bit u4);
        return u4 ? fin4 : fin2;
    endfunction

    task automatic drive_ena(input bit u4, input logic v);
        if (u4) ena4 = v;
        else    ena2 = v;
    endtask

    task automatic drive_data(input bit u4, input logic [31:0] v);
        if (u4) data4 = v;
        else    data2 = v;
    endtask

    // Byte-wise reflected CRC-32, LSB of each octet first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB8_8320;
            else                       r = r >> 1;
        end
        return r;
    endfunction

    // Scoreboard producer: the full 72-octet frame for one payload word.
    task automatic push_frame(input logic [31:0] data);
        logic [7:0]  fr[$];
        logic [31:0] c;
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        for (int i = 0; i < 14; i++) fr.push_back(hdr_bytes[i]);
        fr.push_back(data[31:24]);
        fr.push_back(data[23:16]);
        fr.push_back(data[15:8]);
        fr.push_back(data[7:0]);
        for (int i = 0; i < 42; i++) fr.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) c = crc_byte(c, fr[i]);
        fcs = ~c;
        fr.push_back(fcs[7:0]);
        fr.push_back(fcs[15:8]);
        fr.push_back(fcs[23:16]);
        fr.push_back(fcs[31:24]);
        foreach (fr[i]) exp_q.push_back(fr[i]);
    endtask

    // Request one frame and decode it off the line. Called at a negedge.
    // pulse_at >= 0 raises send_ena again during that dibit; hold keeps
    // send_ena high after the accept.
    task automatic send_frame(input bit u4, input logic [31:0] data,
                              input int pulse_at, input bit hold, input string tag);
        int          div;
        int          wait_cyc;
        int          cyc;
        int          changes;
        int          dib_idx;
        int          oct_idx;
        int          k;
        int          ifg_bad;
        logic [1:0]  dib;
        logic [1:0]  prev;
        logic [7:0]  oct;
        logic [7:0]  exp_oct;
        logic [31:0] residue;

        div = u4 ? 4 : 2;
        push_frame(data);
        drive_data(u4, data);
        drive_ena(u4, 1'b1);
        @(negedge clk);
        check({tag, "_busy_at_accept"}, 32'(s_busy(u4)), 32'd1);
        check({tag, "_finish_cleared"}, 32'(s_fin(u4)), 32'd0);
        if (!hold) drive_ena(u4, 1'b0);
        drive_data(u4, ~data);

        wait_cyc = 0;
        while (s_txen(u4) !== 1'b1 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check({tag, "_first_dibit_latency"},
              32'((wait_cyc >= 1 && wait_cyc <= div) ? 1 : 0), 32'd1);

        cyc     = 0;
        changes = 0;
        dib_idx = 0;
        oct_idx = 0;
        oct     = 8'h00;
        prev    = s_txd(u4);
        residue = 32'hFFFF_FFFF;
        while (s_txen(u4) === 1'b1 && cyc < 5000) begin
            dib = s_txd(u4);
            if (cyc % div == 0) begin
                if (dib_idx == pulse_at)                       drive_ena(u4, 1'b1);
                else if (pulse_at >= 0 && dib_idx == pulse_at + 1) drive_ena(u4, 1'b0);
                oct[2*(dib_idx % 4) +: 2] = dib;
                if (dib_idx % 4 == 3) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("%s_extra_oct%0d", tag, oct_idx), 32'(oct), 32'h1FF);
                    end else begin
                        exp_oct = exp_q.pop_front();
                        check($sformatf("%s_oct%0d", tag, oct_idx), 32'(oct), 32'(exp_oct));
                    end
                    if (oct_idx >= 8) residue = crc_byte(residue, oct);
                    oct_idx++;
                end
                dib_idx++;
            end else if (dib !== prev) begin
                changes++;
            end
            prev = dib;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_txen_cycles"}, 32'(cyc), 32'(288 * div));
        check({tag, "_offslot_changes"}, 32'(changes), 32'd0);
        check({tag, "_crc_residue"}, residue, 32'hDEBB_20E3);
        check({tag, "_octets_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        k       = 0;
        ifg_bad = 0;
        while (s_fin(u4) !== 1'b1 && k < 1000) begin
            if (s_txen(u4) !== 1'b0 || s_txd(u4) !== 2'b00) ifg_bad++;
            @(negedge clk);
            k++;
        end
        check({tag, "_finish_delay"}, 32'(k), 32'(48 * div));
        check({tag, "_ifg_quiet"}, 32'(ifg_bad), 32'd0);
        check({tag, "_busy_at_finish"}, 32'(s_busy(u4)), 32'd0);
    endtask

    initial begin
        int bad;
        int wait_cyc;

        reset = 1'b1;
        ena2  = 1'b0;
        ena4  = 1'b0;
        data2 = 32'h0;
        data4 = 32'h0;
        repeat (5) @(negedge clk);
        check("reset_outs2", {27'd0, txen2, txd1_2, txd0_2, busy2, fin2}, 32'd0);
        check("reset_outs4", {27'd0, txen4, txd1_4, txd0_4, busy4, fin4}, 32'd0);
        reset = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({txen2, txd1_2, txd0_2, busy2, fin2} !== 5'd0) bad++;
            if ({txen4, txd1_4, txd0_4, busy4, fin4} !== 5'd0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        send_frame(1'b0, 32'hDEAD_BEEF, -1, 1'b0, "f1");
        repeat (20) @(negedge clk);
        check("f1_finish_sticky", 32'(fin2), 32'd1);

        // Edge during dibit 100 must be dropped, not queued.
        send_frame(1'b0, 32'h1234_5678, 100, 1'b0, "f2");
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (txen2 !== 1'b0 || busy2 !== 1'b0) bad++;
        end
        check("f2_no_second_frame", 32'(bad), 32'd0);

        send_frame(1'b0, 32'hA5A5_0F0F, -1, 1'b0, "f3");

        // Level held high for about 5000 cycles gives exactly one frame.
        send_frame(1'b0, 32'h0BAD_CAFE, -1, 1'b1, "f4");
        bad = 0;
        repeat (4300) begin
            @(negedge clk);
            if (txen2 !== 1'b0 || busy2 !== 1'b0) bad++;
        end
        check("f4_held_no_retrigger", 32'(bad), 32'd0);
        ena2 = 1'b0;
        repeat (5) @(negedge clk);

        // Reset in the middle of the payload section.
        data2 = 32'hCAFE_F00D;
        ena2  = 1'b1;
        @(negedge clk);
        ena2 = 1'b0;
        wait_cyc = 0;
        while (txen2 !== 1'b1 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("rst_frame_started", 32'(txen2), 32'd1);
        repeat (92 * 2) @(negedge clk);
        check("rst_in_payload", {30'd0, txen2, busy2}, 32'd3);
        reset = 1'b1;
        ena2  = 1'b1;
        @(negedge clk);
        check("rst_outs_next_edge", {27'd0, txen2, txd1_2, txd0_2, busy2, fin2}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txen2 !== 1'b0 || busy2 !== 1'b0 || fin2 !== 1'b0) bad++;
        end
        check("rst_level_no_start", 32'(bad), 32'd0);
        ena2 = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(1'b0, 32'h1357_9BDF, -1, 1'b0, "f5");

        send_frame(1'b1, 32'h0000_0000, -1, 1'b0, "f6_div4");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
